// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with an occupancy count, programmable
// almost-full / almost-empty thresholds, a synchronous flush and
// one-cycle overflow / underflow error pulses.
//
// Build option:
//   FIFO_FWFT_EN  - when defined, the FIFO runs in first-word-fall-through
//                   mode: rd_data shows the head word combinationally while
//                   the FIFO is not empty (0 when empty), and rd_en pops it.
//                   When undefined (default), rd_data is a register loaded
//                   on each accepted read (1-cycle read latency) and held
//                   otherwise.
//
// Parameters:
//   WIDTH      data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 4
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of pointers, count and rd_data
//   wr_en         write request, accepted when not full
//   wr_data       write data
//   rd_en         read request (pop in FWFT mode), accepted when not empty
//   rd_data       read data
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage. Deliberately not reset so it can map onto RAM resources;
  // the pointers and count alone define which entries are live.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // ---------------------------------------------------------------------------
  // Status flags, decoded straight from the count register so they follow
  // the accepting edge with no additional latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AF_THRESH));
    almost_empty = (count_q <= CW'(AE_THRESH));
  end

  // flush wins over both requests: nothing is accepted on a flush edge.
  // A write against a full FIFO is refused even if a read frees a slot on
  // the same edge; this keeps the full flag a pure function of the count.
  always_comb begin
    wr_accept = wr_en && !full  && !flush;
    rd_accept = rd_en && !empty && !flush;
  end

  // ---------------------------------------------------------------------------
  // Pointer, count and error-pulse next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Errors are judged against the flags at the edge; a full FIFO with
      // a concurrent read still reports the refused write.
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write port, no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path.
  // ---------------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
  // Head word falls through; forcing 0 when empty hides stale entries.
  always_comb begin
    rd_data = empty ? '0 : mem[rd_ptr_q];
  end
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Loaded only on an accepted read, so a write into an empty FIFO is
  // not bypassed and rd_data holds between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (flush) begin
      rd_data_d = '0;
    end else if (rd_accept) begin
      rd_data_d = mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    rd_data = rd_data_q;
  end
`endif

  always_comb begin
    count     = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int vectors     = 0;
  int miscompares = 0;

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks count plus every flag derived from it, and both error pulses.
  task automatic chk_status(input string tag, input int c, input bit ov, input bit un);
    chk({tag, ".count"},        32'(count),        32'(c));
    chk({tag, ".empty"},        32'(empty),        32'(c == 0));
    chk({tag, ".full"},         32'(full),         32'(c == DEPTH));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(c >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= AE));
    chk({tag, ".overflow"},     32'(overflow),     32'(ov));
    chk({tag, ".underflow"},    32'(underflow),    32'(un));
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] exp_rd;
    t1[0] = 8'hA1; t1[1] = 8'hB2; t1[2] = 8'hC3; t1[3] = 8'hD4;

    rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #3 rst_n = 1'b0;
    tick(); tick();
    chk_status("reset", 0, 0, 0);
    chk("reset.rd_data", 32'(rd_data), 32'h0);
    rst_n = 1'b1;

    // Read from empty after reset.
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_status("uf", 0, 0, 1);
    chk("uf.rd_data", 32'(rd_data), 32'h0);
    tick();
    chk_status("uf_clear", 0, 0, 0);

    // Four writes then four reads.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = t1[i]; tick();
    end
    wr_en = 1'b0;
    chk_status("t1_wr", 4, 0, 0);
    chk("t1_wr.rd_data", 32'(rd_data), FWFT ? 32'hA1 : 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; tick();
      if (FWFT) exp_rd = (i < 3) ? t1[(i + 1) % 4] : 8'h00;
      else      exp_rd = t1[i];
      chk("t1_rd.rd_data", 32'(rd_data), 32'(exp_rd));
      chk_status("t1_rd", 3 - i, 0, 0);
    end
    rd_en = 1'b0;

    // Fill to full, watching almost_full come up at 6.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
      chk_status("t2_fill", i + 1, 0, 0);
    end
    wr_data = 8'hFF; tick(); wr_en = 1'b0;
    chk_status("t2_ovf", 8, 1, 0);
    chk("t2_ovf.rd_data", 32'(rd_data), FWFT ? 32'h00 : 32'hD4);
    // Full with read+write: write refused, read taken, overflow stays high.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_status("t2_full_rw", 7, 1, 0);
    chk("t2_full_rw.rd_data", 32'(rd_data), FWFT ? 32'h01 : 32'h00);
    for (int i = 1; i < 8; i++) begin
      rd_en = 1'b1; tick();
      if (FWFT) exp_rd = (i < 7) ? 8'(i + 1) : 8'h00;
      else      exp_rd = 8'(i);
      chk("t2_rd.rd_data", 32'(rd_data), 32'(exp_rd));
      chk_status("t2_rd", 7 - i, 0, 0);
    end
    rd_en = 1'b0;

    // Empty with read+write: only the write lands, no bypass.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_status("t2_empty_rw", 1, 0, 1);
    chk("t2_empty_rw.rd_data", 32'(rd_data), FWFT ? 32'h77 : 32'h07);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_status("t2_empty_rd", 0, 0, 0);
    chk("t2_empty_rd.rd_data", 32'(rd_data), FWFT ? 32'h00 : 32'h77);

    // Steady state at count=4 for 20 cycles of read+write.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'(8'h14 + k); tick();
      exp_rd = FWFT ? 8'(8'h11 + k) : 8'(8'h10 + k);
      chk("t4_rw.rd_data", 32'(rd_data), 32'(exp_rd));
      chk("t4_rw.count", 32'(count), 32'd4);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (FWFT) exp_rd = (k < 3) ? 8'(8'h25 + k) : 8'h00;
      else      exp_rd = 8'(8'h24 + k);
      chk("t4_drain.rd_data", 32'(rd_data), 32'(exp_rd));
      chk_status("t4_drain", 3 - k, 0, 0);
    end
    rd_en = 1'b0;

    // Flush with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i); tick();
    end
    wr_en = 1'b0;
    chk_status("t5_fill", 5, 0, 0);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99; tick();
    flush = 1'b0; wr_en = 1'b0;
    chk_status("t5_flush", 0, 0, 0);
    chk("t5_flush.rd_data", 32'(rd_data), 32'h0);
    // Read request on empty during flush raises no underflow.
    flush = 1'b1; rd_en = 1'b1; tick();
    flush = 1'b0; rd_en = 1'b0;
    chk_status("t5_flush_rd", 0, 0, 0);
    wr_en = 1'b1; wr_data = 8'h5A; tick(); wr_en = 1'b0;
    chk_status("t5_wr", 1, 0, 0);
    chk("t5_wr.rd_data", 32'(rd_data), FWFT ? 32'h5A : 32'h00);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_status("t5_rd", 0, 0, 0);
    chk("t5_rd.rd_data", 32'(rd_data), FWFT ? 32'h00 : 32'h5A);

    // Asynchronous reset in the middle of a burst with count=3.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i); tick();
    end
    wr_en = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_status("t6_pre", 3, 0, 0);
    chk("t6_pre.rd_data", 32'(rd_data), FWFT ? 32'h41 : 32'h40);
    wr_en = 1'b1; wr_data = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    chk_status("t6_arst", 0, 0, 0);
    chk("t6_arst.rd_data", 32'(rd_data), 32'h0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_status("t6_held", 0, 0, 0);
    wr_en = 1'b1; wr_data = 8'h3C; tick(); wr_en = 1'b0;
    chk_status("t6_wr", 1, 0, 0);
    chk("t6_wr.rd_data", 32'(rd_data), FWFT ? 32'h3C : 32'h00);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk_status("t6_rd", 0, 0, 0);
    chk("t6_rd.rd_data", 32'(rd_data), FWFT ? 32'h00 : 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and overflow/underflow error pulses.
- Used as the generic buffering element between producer and consumer logic in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries; power of 2, >=4.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count are 0; rd_data is 0; empty=1; almost_empty=1; full=0; almost_full=0; overflow=0; underflow=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all data immediately.
- Storage and pointers:
  - Storage is an array of DEPTH x WIDTH.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - count is a separate register; full and empty are decoded from count.
- Write acceptance:
  - A write is accepted on an edge where wr_en=1 and full=0.
  - mem[wr_ptr] <= wr_data, then wr_ptr increments.
  - A write is rejected when full=1, even if a read is accepted on the same edge.
- Read acceptance (default, registered-output mode):
  - A read is accepted on an edge where rd_en=1 and empty=0.
  - rd_data <= mem[rd_ptr], then rd_ptr increments.
  - rd_data is valid after that edge, i.e. 1-cycle read latency.
  - rd_data holds its value when no read is accepted.
- Simultaneous read and write:
  - Both accepted: count is unchanged.
  - When empty=1, only the write is accepted and count becomes 1. The new word is not bypassed to rd_data.
- Count updates:
  - count increments by 1 on a write-only edge and decrements by 1 on a read-only edge.
  - count never exceeds DEPTH and never goes below 0.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational from the count register.
  - They therefore change in the cycle after the accepting edge, with no extra latency.
- Error pulses:
  - overflow is a registered pulse, high for exactly 1 cycle after an edge with wr_en=1 and full=1.
  - underflow is the same for rd_en=1 and empty=1.
  - In back-to-back error cycles the pulse stays high continuously.
  - Pulses are not generated for cycles where flush=1.
- flush:
  - On an edge with flush=1, pointers and count go to 0 and rd_data goes to 0.
  - flush has priority over wr_en and rd_en on the same edge; neither request is accepted.
- Wrap-around: after DEPTH writes and DEPTH reads, pointers return to 0. Data order is preserved across any number of wraps.

Optional Feature:
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data is combinationally mem[rd_ptr] whenever empty=0, and 0 when empty=1.
  - rd_en acts as a pop/acknowledge: the next word appears after the accepting edge.
  - Read latency is 0.
  - A word written at edge N is visible on rd_data after edge N, together with empty=0.
  - All count, flag and error rules are unchanged.
- Not defined: registered-output mode as described in Behaviour.

Test Plan (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2):
- Write A1, B2, C3, D4, then four reads → rd_data A1, B2, C3, D4 on successive cycles after each read edge. count goes 4 → 0; empty=1 at the end; no error pulses.
- Write 8 words 00..07 → full=1, count=8, almost_full high from count=6. A 9th write of FF → overflow pulses 1 cycle; FF is never read back.
- Read from empty after reset → underflow pulses 1 cycle; rd_data stays 0; count stays 0.
- Hold count=4, drive wr_en=rd_en=1 for 20 cycles with incrementing data → count stays 4. Read order is continuous and pointers wrap at least twice.
- Fill with 5 words, assert flush with wr_en=1 → count=0, empty=1, rd_data=0. A next write of 5A followed by a read returns 5A.
- Assert rst_n low asynchronously mid-burst with count=3 → all outputs take reset values immediately, before the next clock edge. With FIFO_FWFT_EN defined, writing 3C makes rd_data=3C one edge later, with no rd_en.
